// File: rtl/and_bist_sequencer_if.sv
// and_bist_sequencer_if: start/clear controls, AND-stage operands/result and BIST status.
interface and_bist_sequencer_if #(
    parameter int ERR_W = 8
);
    logic             start;
    logic             clr_err;
    logic             c;
    logic             a;
    logic             b;
    logic             busy;
    logic             done;
    logic             pass;
    logic             fail_valid;
    logic [1:0]       fail_idx;
    logic [ERR_W-1:0] err_count;
    modport master (
        input  start, clr_err, c,
        output a, b, busy, done, pass, fail_valid, fail_idx, err_count
    );
    modport slave (
        output start, clr_err, c,
        input  a, b, busy, done, pass, fail_valid, fail_idx, err_count
    );
endinterface

// File: rtl/and_bist_sequencer.sv
// and_bist_sequencer: self-checking BIST driving a 2-input AND stage through all four vectors.
// Define AND_BIST_CONTINUOUS_EN to loop passes forever instead of a single run per start.
module and_bist_sequencer #(
    parameter int SETTLE_CYCLES = 2,
    parameter int ERR_W         = 8
) (
    input logic                 clk,
    input logic                 rst,
    and_bist_sequencer_if.master bus
);
    typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;
    localparam int CW = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [ERR_W-1:0] ERR_MAX = '1;
    state_t           state, state_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [1:0]       vec, vec_n;
    logic             pass_q, pass_n;
    logic             fv_q, fv_n;
    logic [1:0]       fidx_q, fidx_n;
    logic [ERR_W-1:0] err_q, err_n;
    logic             mis;
    assign mis            = (state == CHECK) && (bus.c != (vec[1] & vec[0]));
    assign bus.a          = vec[1];
    assign bus.b          = vec[0];
    assign bus.busy       = state != IDLE;
    assign bus.done       = state == DONE;
    assign bus.pass       = pass_q;
    assign bus.fail_valid = fv_q;
    assign bus.fail_idx   = fidx_q;
    assign bus.err_count  = err_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            vec    <= '0;
            pass_q <= 1'b0;
            fv_q   <= 1'b0;
            fidx_q <= '0;
            err_q  <= '0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            vec    <= vec_n;
            pass_q <= pass_n;
            fv_q   <= fv_n;
            fidx_q <= fidx_n;
            err_q  <= err_n;
        end
    end
    // clr_err wins over a same-edge mismatch increment
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        vec_n   = vec;
        pass_n  = pass_q;
        fv_n    = fv_q || mis;
        fidx_n  = (mis && !fv_q) ? vec : fidx_q;
        err_n   = bus.clr_err ? '0 : (mis && err_q != ERR_MAX) ? err_q + 1'b1 : err_q;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_n = SETTLE;
                    cnt_n   = '0;
                    vec_n   = '0;
                    pass_n  = 1'b0;
                    fv_n    = 1'b0;
                    fidx_n  = '0;
                end
            end
            SETTLE: begin
                cnt_n   = cnt + 1'b1;
                state_n = (cnt == CNT_LAST) ? CHECK : SETTLE;
            end
            CHECK: begin
                if (vec == 2'd3) begin
                    state_n = DONE;
                    pass_n  = !fv_n;
                end else begin
                    state_n = SETTLE;
                    vec_n   = vec + 1'b1;
                    cnt_n   = '0;
                end
            end
            DONE: begin
`ifdef AND_BIST_CONTINUOUS_EN
                state_n = SETTLE;
                cnt_n   = '0;
                vec_n   = '0;
                fv_n    = 1'b0;
                fidx_n  = '0;
`else
                state_n = IDLE;
`endif
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_and_bist_sequencer.sv
// tb_and_bist_sequencer: directed checks of the AND BIST sequencer with injected AND-stage faults.
module tb_and_bist_sequencer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] mode = 2'd0;
    int         checks = 0;
    int         failures = 0;
    and_bist_sequencer_if #(.ERR_W(8)) if0 ();
    and_bist_sequencer_if #(.ERR_W(2)) if1 ();
    and_bist_sequencer #(.SETTLE_CYCLES(2), .ERR_W(8)) dut0 (.clk(clk), .rst(rst), .bus(if0));
    and_bist_sequencer #(.SETTLE_CYCLES(1), .ERR_W(2)) dut1 (.clk(clk), .rst(rst), .bus(if1));
    always #5 clk = ~clk;
    // mode 0: correct AND, 1: stuck-at-1, 2: OR fault
    function automatic logic stage(input logic [1:0] m, input logic x, input logic y);
        return m == 2'd0 ? (x & y) : m == 2'd1 ? 1'b1 : (x | y);
    endfunction
    assign if0.c = stage(mode, if0.a, if0.b);
    assign if1.c = stage(mode, if1.a, if1.b);
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic run0(input bit ign);
        if0.start = 1'b1;
        tick;
        if0.start = 1'b0;
        check("vec0", {if0.a, if0.b}, 0);
        check("busy_start", if0.busy, 1);
        for (int e = 1; e <= 13; e++) begin
            if0.start = ign && (e == 1 || e == 3 || e == 6);
            tick;
            if (e % 3 == 0 && e < 12) check("vec", {if0.a, if0.b}, e / 3);
            if (e == 11) check("done_early", if0.done, 0);
            if (e == 12) begin
                check("done", if0.done, 1);
                check("busy_done", if0.busy, 1);
            end
            if (e == 13) begin
                check("done_len", if0.done, 0);
                check("busy_end", if0.busy, 0);
                check("hold11", {if0.a, if0.b}, 3);
            end
        end
        if0.start = 1'b0;
    endtask
    task automatic wait_done1(input string tag);
        int n = 0;
        while (!if1.done && n < 40) begin
            tick;
            n++;
        end
        check(tag, if1.done, 1);
    endtask
    initial begin
        if0.start = 1'b0; if0.clr_err = 1'b0;
        if1.start = 1'b0; if1.clr_err = 1'b0;
        tick;
        tick;
        rst = 1'b0;
        check("rst_ab", {if0.a, if0.b}, 0);
        check("rst_status", {if0.busy, if0.done, if0.pass, if0.fail_valid}, 0);
        check("rst_idx", if0.fail_idx, 0);
        check("rst_err", if0.err_count, 0);
`ifdef AND_BIST_CONTINUOUS_EN
        begin
            int n;
            if0.start = 1'b1;
            tick;
            if0.start = 1'b0;
            n = 0;
            while (!if0.done && n < 20) begin tick; n++; end
            check("cont_first", n, 12);
            for (int p = 0; p < 3; p++) begin
                n = 0;
                do begin
                    tick;
                    n++;
                    if (!if0.busy) check("cont_busy", if0.busy, 1);
                end while (!if0.done && n < 30);
                check("cont_period", n, 13);
                check("cont_pass", if0.pass, 1);
            end
        end
`else
        mode = 2'd0;
        run0(1'b0);
        check("and_pass", if0.pass, 1);
        check("and_fv", if0.fail_valid, 0);
        check("and_err", if0.err_count, 0);
        mode = 2'd1;
        run0(1'b0);
        check("sa1_err", if0.err_count, 3);
        check("sa1_pass", if0.pass, 0);
        check("sa1_fv", if0.fail_valid, 1);
        check("sa1_idx", if0.fail_idx, 0);
        if0.clr_err = 1'b1;
        tick;
        if0.clr_err = 1'b0;
        check("clr0", if0.err_count, 0);
        mode = 2'd2;
        run0(1'b0);
        check("or_err", if0.err_count, 2);
        check("or_idx", if0.fail_idx, 1);
        check("or_pass", if0.pass, 0);
        mode = 2'd0;
        run0(1'b1);
        check("rerun_pass", if0.pass, 1);
        check("rerun_fv", if0.fail_valid, 0);
        check("rerun_err", if0.err_count, 2);
        mode = 2'd1;
        if1.start = 1'b1;
        tick;
        if1.start = 1'b0;
        wait_done1("sat_done1");
        check("sat_err1", if1.err_count, 3);
        tick;
        if1.start = 1'b1;
        tick;
        if1.start = 1'b0;
        wait_done1("sat_done2");
        check("sat_err2", if1.err_count, 3);
        check("sat_pass", if1.pass, 0);
        tick;
        if1.clr_err = 1'b1;
        tick;
        if1.clr_err = 1'b0;
        check("sat_clr", if1.err_count, 0);
        if1.start = 1'b1;
        tick;
        if1.start = 1'b0;
        tick;
        if1.clr_err = 1'b1;
        tick;
        if1.clr_err = 1'b0;
        check("clr_same_edge", if1.err_count, 0);
        wait_done1("clr_run_done");
        check("clr_run_err", if1.err_count, 2);
        tick;
        if0.start = 1'b1;
        tick;
        if0.start = 1'b0;
        repeat (6) tick;
        check("pre_rst_ab", {if0.a, if0.b}, 2);
        check("pre_rst_err", if0.err_count, 4);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_ab", {if0.a, if0.b}, 0);
        check("mid_rst_status", {if0.busy, if0.done, if0.pass, if0.fail_valid}, 0);
        check("mid_rst_idx", if0.fail_idx, 0);
        check("mid_rst_err", if0.err_count, 0);
        tick;
        rst = 1'b0;
        begin
            logic seen = 1'b0;
            for (int i = 0; i < 15; i++) begin
                tick;
                seen = seen | if0.done | if0.busy;
            end
            check("no_done_after_rst", seen, 0);
        end
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
